// File: rtl/serial_controller_fifo.sv
`default_nettype none
// ============================================================================
// Module   : serial_controller_fifo
// Brief    : Full-duplex UART with TX/RX word FIFOs. Multi-byte words are sent
//            low byte first. Define SERIAL_PARITY_EN for 8E1 framing (else 8N1).
// Revision : 1.0 - initial release
// ============================================================================
module serial_controller_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    send,
    input  logic [8*WORD_BYTES-1:0] data_in,
    input  logic                    read,
    input  logic                    rxd,
    input  logic                    clear_err,
    output logic                    txd,
    output logic                    valid,
    output logic [8*WORD_BYTES-1:0] data_out,
    output logic                    tx_full,
    output logic                    tx_idle,
    output logic [3:0]              err_flags
);
    localparam int c_W       = 8*WORD_BYTES;
    localparam int c_DIV_RAW = (CLK_HZ + BAUD*8) / (BAUD*16);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_DW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [1:0]     c_LAST_IDX  = 2'(WORD_BYTES-1);
    localparam logic [c_W-1:0] c_BYTE_MASK = c_W'(8'hFF);

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_LOAD = 3'd1, TX_START = 3'd2, TX_DATA = 3'd3, TX_STOP = 3'd4
`ifdef SERIAL_PARITY_EN
        , TX_PARITY = 3'd5
`endif
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAIT_HIGH = 3'd4
`ifdef SERIAL_PARITY_EN
        , RX_PARITY = 3'd5
`endif
    } rx_state_t;

    // Oversampling tick, 16 per bit
    logic [c_DW-1:0] r_div_cnt;
    logic            w_tick;
    assign w_tick = (r_div_cnt == c_DW'(c_DIV-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // TX FIFO
    logic [c_W-1:0] r_tx_mem [FIFO_DEPTH];
    logic [c_AW:0]  r_tx_wr, r_tx_rd;
    logic           w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_ovr;

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr == {~r_tx_rd[c_AW], r_tx_rd[c_AW-1:0]});
    assign w_tx_push  = send && (!w_tx_full || w_tx_pop);
    assign w_tx_ovr   = send && w_tx_full && !w_tx_pop;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[c_AW-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
        end
    end

    // TX serialiser
    tx_state_t      r_tx_state, w_tx_state_n;
    logic [c_W-1:0] r_tx_word, w_tx_word_n, w_tx_shift;
    logic [1:0]     r_tx_idx, w_tx_idx_n;
    logic [2:0]     r_tx_bit, w_tx_bit_n;
    logic [3:0]     r_tx_tcnt, w_tx_tcnt_n;
    logic [7:0]     w_tx_byte;
    logic           w_tx_bit_end;

    assign w_tx_shift   = r_tx_word >> {r_tx_idx, 3'b000};
    assign w_tx_byte    = w_tx_shift[7:0];
    assign w_tx_bit_end = w_tick && (r_tx_tcnt == 4'd15);

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_word_n  = r_tx_word;
        w_tx_idx_n   = r_tx_idx;
        w_tx_bit_n   = r_tx_bit;
        w_tx_tcnt_n  = r_tx_tcnt;
        w_tx_pop     = 1'b0;
        if (w_tick && r_tx_state != TX_IDLE && r_tx_state != TX_LOAD)
            w_tx_tcnt_n = r_tx_tcnt + 1'b1;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty) begin
                w_tx_pop     = 1'b1;
                w_tx_word_n  = r_tx_mem[r_tx_rd[c_AW-1:0]];
                w_tx_idx_n   = '0;
                w_tx_state_n = TX_LOAD;
            end
            TX_LOAD: if (w_tick) w_tx_state_n = TX_START;
            TX_START: if (w_tx_bit_end) begin
                w_tx_bit_n   = '0;
                w_tx_state_n = TX_DATA;
            end
            TX_DATA: if (w_tx_bit_end) begin
                w_tx_bit_n = r_tx_bit + 1'b1;
`ifdef SERIAL_PARITY_EN
                if (r_tx_bit == 3'd7) w_tx_state_n = TX_PARITY;
            end
            TX_PARITY: if (w_tx_bit_end) begin
                w_tx_state_n = TX_STOP;
`else
                if (r_tx_bit == 3'd7) w_tx_state_n = TX_STOP;
`endif
            end
            TX_STOP: if (w_tx_bit_end) begin
                // Chain straight into the next byte or word so there is no idle gap
                if (r_tx_idx != c_LAST_IDX) begin
                    w_tx_idx_n   = r_tx_idx + 1'b1;
                    w_tx_state_n = TX_START;
                end else if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_word_n  = r_tx_mem[r_tx_rd[c_AW-1:0]];
                    w_tx_idx_n   = '0;
                    w_tx_state_n = TX_START;
                end else begin
                    w_tx_state_n = TX_IDLE;
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_word  <= '0;
            r_tx_idx   <= '0;
            r_tx_bit   <= '0;
            r_tx_tcnt  <= '0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_word  <= w_tx_word_n;
            r_tx_idx   <= w_tx_idx_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_tcnt  <= w_tx_tcnt_n;
        end
    end

    always_comb begin
        case (r_tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = w_tx_byte[r_tx_bit];
`ifdef SERIAL_PARITY_EN
            TX_PARITY: txd = ^w_tx_byte;
`endif
            default:   txd = 1'b1;
        endcase
    end

    assign tx_full = w_tx_full;
    assign tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);

    // RX synchroniser and deserialiser
    logic r_rx_s1, r_rx_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
        end
    end

    rx_state_t      r_rx_state, w_rx_state_n;
    logic [3:0]     r_rx_tcnt, w_rx_tcnt_n;
    logic [2:0]     r_rx_bit, w_rx_bit_n;
    logic [7:0]     r_rx_byte, w_rx_byte_n;
    logic [1:0]     r_rx_idx, w_rx_idx_n;
    logic [c_W-1:0] r_rx_word, w_rx_word_n, w_rx_placed;
    logic           w_rx_sample, w_rx_push, w_frame_err, w_par_err;

    assign w_rx_sample = w_tick && (r_rx_tcnt == 4'd15);
    assign w_rx_placed = (r_rx_word & ~(c_BYTE_MASK << {r_rx_idx, 3'b000}))
                       | (c_W'(r_rx_byte) << {r_rx_idx, 3'b000});

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_tcnt_n  = r_rx_tcnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_byte_n  = r_rx_byte;
        w_rx_idx_n   = r_rx_idx;
        w_rx_word_n  = r_rx_word;
        w_rx_push    = 1'b0;
        w_frame_err  = 1'b0;
        w_par_err    = 1'b0;
        if (w_tick && r_rx_state != RX_IDLE && r_rx_state != RX_WAIT_HIGH)
            w_rx_tcnt_n = r_rx_tcnt + 1'b1;
        case (r_rx_state)
            RX_IDLE: if (!r_rx_s2) begin
                w_rx_tcnt_n  = '0;
                w_rx_state_n = RX_START;
            end
            RX_START: if (w_tick && r_rx_tcnt == 4'd7) begin
                w_rx_tcnt_n  = '0;
                w_rx_bit_n   = '0;
                w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (w_rx_sample) begin
                w_rx_byte_n = {r_rx_s2, r_rx_byte[7:1]};
                w_rx_bit_n  = r_rx_bit + 1'b1;
`ifdef SERIAL_PARITY_EN
                if (r_rx_bit == 3'd7) w_rx_state_n = RX_PARITY;
            end
            RX_PARITY: if (w_rx_sample) begin
                if (r_rx_s2 != ^r_rx_byte) begin
                    w_par_err    = 1'b1;
                    w_rx_idx_n   = '0;
                    w_rx_state_n = RX_WAIT_HIGH;
                end else begin
                    w_rx_state_n = RX_STOP;
                end
`else
                if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
`endif
            end
            RX_STOP: if (w_rx_sample) begin
                if (!r_rx_s2) begin
                    w_frame_err  = 1'b1;
                    w_rx_idx_n   = '0;
                    w_rx_state_n = RX_WAIT_HIGH;
                end else begin
                    w_rx_word_n  = w_rx_placed;
                    w_rx_push    = (r_rx_idx == c_LAST_IDX);
                    w_rx_idx_n   = (r_rx_idx == c_LAST_IDX) ? 2'd0 : r_rx_idx + 1'b1;
                    w_rx_state_n = RX_IDLE;
                end
            end
            RX_WAIT_HIGH: if (r_rx_s2) w_rx_state_n = RX_IDLE;
            default: w_rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bit   <= '0;
            r_rx_byte  <= '0;
            r_rx_idx   <= '0;
            r_rx_word  <= '0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_tcnt  <= w_rx_tcnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_byte  <= w_rx_byte_n;
            r_rx_idx   <= w_rx_idx_n;
            r_rx_word  <= w_rx_word_n;
        end
    end

    // RX FIFO with registered show-ahead head
    logic [c_W-1:0]  r_rx_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_rx_wr, r_rx_rd, w_rx_cnt;
    logic [c_AW-1:0] w_rx_rd_nxt;
    logic [c_W-1:0]  r_data_out;
    logic            w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr, w_rx_ovr;

    assign w_rx_empty  = (r_rx_wr == r_rx_rd);
    assign w_rx_full   = (r_rx_wr == {~r_rx_rd[c_AW], r_rx_rd[c_AW-1:0]});
    assign w_rx_cnt    = r_rx_wr - r_rx_rd;
    assign w_rx_rd_nxt = r_rx_rd[c_AW-1:0] + 1'b1;
    assign w_rx_pop    = read && !w_rx_empty;
    assign w_rx_wr     = w_rx_push && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr    = w_rx_push && w_rx_full && !w_rx_pop;

    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wr[c_AW-1:0]] <= w_rx_word_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_rx_wr)  r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_pop) begin
                if (w_rx_cnt > {{c_AW{1'b0}}, 1'b1}) r_data_out <= r_rx_mem[w_rx_rd_nxt];
                else if (w_rx_wr)                    r_data_out <= w_rx_word_n;
            end else if (w_rx_wr && w_rx_empty) begin
                r_data_out <= w_rx_word_n;
            end
        end
    end

    assign valid    = !w_rx_empty;
    assign data_out = r_data_out;

    // Sticky errors; an event coincident with clear wins
    logic [3:0] r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= '0;
        else        r_err <= (clear_err ? 4'b0000 : r_err)
                           | {w_par_err, w_frame_err, w_rx_ovr, w_tx_ovr};
    end

    assign err_flags = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_controller_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_controller_fifo
// Brief    : Directed/random bench with a line-level UART reference and queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_controller_fifo;
    localparam int WB  = 2;
    localparam int W   = 8*WB;
    localparam int BIT = 160;

    logic         clk = 1'b0, rst_n = 1'b0, send = 1'b0, read = 1'b0, clear_err = 1'b0;
    logic         loop_en = 1'b1, rx_drv = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         txd, valid, tx_full, tx_idle, rxd;
    logic [W-1:0] data_out;
    logic [3:0]   err_flags;

    int           n_cmp = 0, n_fail = 0, mon_bad = 0;
    logic [7:0]   mon_q[$];
    logic [7:0]   exp_tx[$];
    logic [W-1:0] exp_rx[$];
    logic [W-1:0] rw;

    assign rxd = loop_en ? txd : rx_drv;
    always #5 clk = ~clk;

    serial_controller_fifo #(
        .CLK_HZ(1600000), .BAUD(10000), .WORD_BYTES(WB), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .data_in(data_in), .read(read),
        .rxd(rxd), .clear_err(clear_err), .txd(txd), .valid(valid),
        .data_out(data_out), .tx_full(tx_full), .tx_idle(tx_idle), .err_flags(err_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        check({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (tx_idle !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        check({tag, "_txidle"}, 32'(tx_idle), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    task automatic read_one(input string tag);
        logic [W-1:0] e;
        wait_valid(tag);
        e = exp_rx.pop_front();
        check({tag, "_data"}, 32'(data_out), 32'(e));
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_txlen"}, 32'(mon_q.size()), 32'(exp_tx.size()));
        while (exp_tx.size() > 0 && mon_q.size() > 0)
            check({tag, "_txbyte"}, 32'(mon_q.pop_front()), 32'(exp_tx.pop_front()));
        check({tag, "_txframe"}, 32'(mon_bad), 32'd0);
        mon_q.delete();
        exp_tx.delete();
    endtask

    task automatic clear_errors(input string tag);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check({tag, "_clr"}, 32'(err_flags), 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef SERIAL_PARITY_EN
        rx_drv = (^b) ^ par_flip;
        repeat (BIT) @(negedge clk);
`endif
        rx_drv = stop_bit;
        repeat (BIT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic queue_word(input logic [W-1:0] w);
        exp_rx.push_back(w);
        exp_tx.push_back(w[7:0]);
        exp_tx.push_back(w[15:8]);
    endtask

    // Line-level reference receiver on TxD: centre-sampled 160-clock bits
    initial begin
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BIT/2) @(negedge clk);
                if (txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        mb[i] = txd;
                    end
`ifdef SERIAL_PARITY_EN
                    repeat (BIT) @(negedge clk);
                    if (txd !== ^mb) mon_bad++;
`endif
                    repeat (BIT) @(negedge clk);
                    if (txd !== 1'b1) mon_bad++;
                    mon_q.push_back(mb);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_txidle", 32'(tx_idle), 32'd1);
        check("rst_txfull", 32'(tx_full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single word loopback
        send = 1'b1; data_in = 16'hA53C; queue_word(16'hA53C);
        @(negedge clk);
        send = 1'b0;
        check("single_busy", 32'(tx_idle), 32'd0);
        read_one("single");
        check("single_empty", 32'(valid), 32'd0);
        wait_idle("single");
        check_tx("single");

        // Five back-to-back random words, sixth dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rw = W'($urandom);
            send = 1'b1; data_in = rw; queue_word(rw);
        end
        @(negedge clk);
        check("b2b_full", 32'(tx_full), 32'd1);
        data_in = W'($urandom);
        @(negedge clk);
        send = 1'b0;
        check("b2b_ovf", 32'(err_flags), 32'd1);
        for (int i = 0; i < 5; i++) read_one("b2b");
        wait_idle("b2b");
        check_tx("b2b");
        check("b2b_err", 32'(err_flags), 32'd1);
        clear_errors("b2b");

        // RX overrun: five words with no reads
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rw = W'($urandom);
            send = 1'b1; data_in = rw; queue_word(rw);
        end
        @(negedge clk);
        send = 1'b0;
        wait_idle("ovr");
        check_tx("ovr");
        check("ovr_err", 32'(err_flags), 32'd2);
        rw = exp_rx[3];
        for (int i = 0; i < 4; i++) begin
            check("ovr_valid", 32'(valid), 32'd1);
            check("ovr_data", 32'(data_out), 32'(exp_rx.pop_front()));
            read = 1'b1;
            @(negedge clk);
            read = 1'b0;
        end
        exp_rx.delete();
        check("ovr_empty", 32'(valid), 32'd0);
        check("ovr_hold", 32'(data_out), 32'(rw));
        clear_errors("ovr");

        // Framing error then a good word, RxD driven directly
        loop_en = 1'b0;
        drive_frame(8'($urandom), 1'b0, 1'b0);
        check("ferr_flag", 32'(err_flags), 32'd4);
        check("ferr_novalid", 32'(valid), 32'd0);
        drive_frame(8'h34, 1'b1, 1'b0);
        drive_frame(8'h12, 1'b1, 1'b0);
        exp_rx.push_back(16'h1234);
        read_one("ferr");
        check("ferr_only", 32'(valid), 32'd0);
        clear_errors("ferr");

        // Short start-bit glitch, then recovery with a random word
        rx_drv = 1'b0;
        repeat (30) @(negedge clk);
        rx_drv = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_err", 32'(err_flags), 32'd0);
        rw = W'($urandom);
        drive_frame(rw[7:0], 1'b1, 1'b0);
        drive_frame(rw[15:8], 1'b1, 1'b0);
        exp_rx.push_back(rw);
        read_one("glitch");

`ifdef SERIAL_PARITY_EN
        // Bad parity byte discarded, correct frames accepted
        drive_frame(8'h07, 1'b1, 1'b1);
        check("par_flag", 32'(err_flags), 32'd8);
        check("par_novalid", 32'(valid), 32'd0);
        drive_frame(8'h07, 1'b1, 1'b0);
        drive_frame(8'h00, 1'b1, 1'b0);
        exp_rx.push_back(16'h0007);
        read_one("par");
        clear_errors("par");
`endif

        // Asynchronous reset in the middle of a frame
        loop_en = 1'b1;
        @(negedge clk);
        send = 1'b1; data_in = 16'h00FF;
        @(negedge clk);
        send = 1'b0;
        repeat (BIT*3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_idle", 32'(tx_idle), 32'd1);
        check("mid_rst_valid", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_controller_fifo.md
Name: serial_controller_fifo

Overview:
Parametrised successor to the single-word serial controller: full-duplex 8-bit UART with configurable baud rate and word width. Transmit and receive FIFOs let the CPU queue several words without polling per byte. Multi-byte words are split and reassembled on the serial line, low byte first. Sits between the CPU's serial send/read strobes and the board RxD/TxD pins, on the CPU clock (c25Clk).

Parameters:
CLK_HZ, 25000000, input clock frequency in Hz
BAUD, 115200, line rate; tick divisor DIV = round(CLK_HZ/(BAUD*16)), minimum 1
WORD_BYTES, 2, bytes per CPU word (1..4); W = 8*WORD_BYTES
FIFO_DEPTH, 8, entries per FIFO; power of 2, at least 2

Ports:
Clock  in  1  system clock; all logic on posedge
Reset  in  1  asynchronous, active-low; 0 = reset
Send  in  1  one-cycle strobe; pushes DataIn into TX FIFO
DataIn  in  W  word to transmit
Read  in  1  one-cycle strobe; pops RX FIFO head
RxD  in  1  serial input, asynchronous, idle high
ClearErr  in  1  one-cycle strobe; clears sticky error flags
TxD  out  1  serial output, idle high
Valid  out  1  RX FIFO non-empty
DataOut  out  W  RX FIFO head (show-ahead)
TxFull  out  1  TX FIFO full
TxIdle  out  1  TX FIFO empty and serialiser idle
ErrFlags  out  4  sticky flags: [0] TX overflow, [1] RX overrun, [2] framing error, [3] parity error

Behaviour:
- Reset state: TxD=1, Valid=0, DataOut=0, TxFull=0, TxIdle=1, ErrFlags=0. Both FIFOs are empty. Both FSMs are in IDLE with counters at 0.
- Tick generator: free-running counter from 0 to DIV-1. Emits a one-cycle tick on wrap. There are 16 ticks per bit.
- TX FIFO push on Send:
  - if not full, store DataIn;
  - if full, drop the word and set ErrFlags[0].
  - TxFull updates the cycle after a push.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: when the FIFO is non-empty, pop a word, set byte index 0, and enter START on the next tick.
  - Each bit lasts 16 ticks. Data bits go out LSB first. STOP drives 1 for 16 ticks.
  - After STOP: if byte index < WORD_BYTES-1, increment the index and go to START (next higher byte); otherwise go to IDLE.
  - Consecutive words are sent back-to-back with no idle bit.
- RX path: RxD passes through a 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP.
  - IDLE: a synchronised low starts the tick count.
  - START: re-sample at tick 7. If high, it is a glitch: return to IDLE.
  - DATA: sample each bit at its centre (tick 15 after the previous sample).
  - STOP: sample the stop bit. If it is 0, set ErrFlags[2], discard the byte, reset the byte index to 0, and wait for line high before IDLE. Otherwise place the byte at position index.
  - When WORD_BYTES bytes are assembled, push the word. Valid rises the cycle after the push.
- RX FIFO:
  - Push when full: drop the word, set ErrFlags[1].
  - Read when empty: ignored.
  - Simultaneous Read and push when full: both succeed, no overrun.
  - DataOut shows the new head the cycle after a pop. DataOut holds its last value when empty.
- Simultaneous Send and TX pop when full: the pop frees the slot, so the push succeeds.
- Errors: ClearErr clears all flags. If an error event occurs in the same cycle as ClearErr, the flag stays set.
- Reset mid-frame: TxD returns to 1 immediately (asynchronous). Any partial frame or word is abandoned.
- Pointers are log2(FIFO_DEPTH) bits wide plus one wrap bit. Full = pointers equal except the wrap bit.

Optional Feature:
Macro SERIAL_PARITY_EN.
- Defined:
  - frames are 8E1; TX inserts an even-parity bit after the data bits;
  - RX checks it; on mismatch, set ErrFlags[3], discard the byte, and reset the byte index to 0.
- Undefined:
  - frames are 8N1; the PARITY states do not exist;
  - ErrFlags[3] is tied to 0.

Test Plan:
Use CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 clocks per bit), WORD_BYTES=2, FIFO_DEPTH=4. TxD is looped to RxD unless stated.
- Reset: hold Reset=0 and check TxD=1, Valid=0, ErrFlags=0, TxIdle=1. Then Send 16'hA53C -> TxD shows the frames for 0x3C then 0xA5, LSB first. Valid rises one cycle after the second stop-bit sample; DataOut=16'hA53C.
- Send 5 words back-to-back (0x0001..0x0005) with FIFO_DEPTH=4 -> one word pops immediately, so all 5 are accepted. A 6th Send in the next cycle is dropped and sets ErrFlags[0]. Five words are received in order.
- Leave Read low while 5 words arrive -> the 5th word is dropped, ErrFlags[1]=1, and the first 4 read back unchanged. ClearErr -> ErrFlags=0.
- Drive RxD directly with stop bit 0 on the first byte, then a valid two-byte word 0x1234 -> ErrFlags[2]=1 and the only word received is 0x1234.
- Drive a 3-tick low glitch on RxD -> no byte is assembled; Valid stays 0.
- With SERIAL_PARITY_EN, inject a byte 0x07 with parity bit 0 -> ErrFlags[3]=1 and the byte is discarded. The correct frame (parity bit 1) is accepted.
